// File: rtl/ahb2apb_bridge.sv
// ahb2apb_bridge: AHB-Lite slave to two-slave APB master bridge, single transfers only
//   iPCLK, iPRESET            shared clock, async active-high reset
//   iHSEL..iHREADY            AHB address/data phase inputs
//   oHREADYOUT/oHRESP/oHRDATA registered AHB response
//   oPADDR..oPWDATA           APB master outputs, one PSEL per slave
//   iPRDATA0/1, iPREADY0/1    APB slave responses
module ahb2apb_bridge #(
  parameter logic [3:0] ADDR_SLAVE_0 = 4'h0,
  parameter logic [3:0] ADDR_SLAVE_1 = 4'h1
) (
  input  logic        iPCLK,
  input  logic        iPRESET,
  input  logic        iHSEL,
  input  logic [31:0] iHADDR,
  input  logic [1:0]  iHTRANS,
  input  logic        iHWRITE,
  input  logic [31:0] iHWDATA,
  input  logic        iHREADY,
  output logic        oHREADYOUT,
  output logic        oHRESP,
  output logic [31:0] oHRDATA,
  output logic [31:0] oPADDR,
  output logic        oPSEL0,
  output logic        oPSEL1,
  output logic        oPENABLE,
  output logic        oPWRITE,
  output logic [31:0] oPWDATA,
  input  logic [31:0] iPRDATA0,
  input  logic [31:0] iPRDATA1,
  input  logic        iPREADY0,
  input  logic        iPREADY1
);
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] WLATCH = 3'd1;
  localparam logic [2:0] SETUP  = 3'd2;
  localparam logic [2:0] ACCESS = 3'd3;
  localparam logic [2:0] ERR1   = 3'd4;
  localparam logic [2:0] ERR2   = 3'd5;
  logic [2:0] state;
  logic       slvSel;
  logic       accept;
  logic       hitSlave0;
  logic       hitSlave1;
  logic       selReady;
  logic       unusedHtrans;
  // NONSEQ and SEQ both have bit 1 set; bit 0 only separates them
  assign accept       = iHSEL & iHREADY & iHTRANS[1];
  assign unusedHtrans = iHTRANS[0];
  assign hitSlave0    = iHADDR[31:28] == ADDR_SLAVE_0;
  assign hitSlave1    = iHADDR[31:28] == ADDR_SLAVE_1;
  // only the slave chosen at accept time may end the access phase
  assign selReady     = slvSel ? iPREADY1 : iPREADY0;
  always_ff @(posedge iPCLK or posedge iPRESET)
    if (iPRESET) begin
      state      <= IDLE;
      slvSel     <= 1'b0;
      oHREADYOUT <= 1'b1;
      oHRESP     <= 1'b0;
      oHRDATA    <= '0;
      oPADDR     <= '0;
      oPSEL0     <= 1'b0;
      oPSEL1     <= 1'b0;
      oPENABLE   <= 1'b0;
      oPWRITE    <= 1'b0;
      oPWDATA    <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          oPADDR     <= iHADDR;
          oPWRITE    <= iHWRITE;
          oHREADYOUT <= 1'b0;
          slvSel     <= hitSlave1 & ~hitSlave0;
          if (!hitSlave0 && !hitSlave1) begin
            oHRESP <= 1'b1;
            state  <= ERR1;
          end else if (iHWRITE) begin
            state <= WLATCH;
          end else begin
            // reads skip the data latch, so PSEL goes up with the SETUP state
            oPSEL0 <= hitSlave0;
            oPSEL1 <= hitSlave1 & ~hitSlave0;
            state  <= SETUP;
          end
        end
        WLATCH: begin
          oPWDATA <= iHWDATA;
          oPSEL0  <= ~slvSel;
          oPSEL1  <= slvSel;
          state   <= SETUP;
        end
        SETUP: begin
          oPENABLE <= 1'b1;
          state    <= ACCESS;
        end
        ACCESS: if (selReady) begin
          if (!oPWRITE) oHRDATA <= slvSel ? iPRDATA1 : iPRDATA0;
          oHREADYOUT <= 1'b1;
          oPSEL0     <= 1'b0;
          oPSEL1     <= 1'b0;
          oPENABLE   <= 1'b0;
          state      <= IDLE;
        end
        // two-cycle ERROR response: HREADYOUT low then high with HRESP held
        ERR1: begin
          oHREADYOUT <= 1'b1;
          state      <= ERR2;
        end
        ERR2: begin
          oHRESP <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_ahb2apb_bridge.sv
// tb_ahb2apb_bridge: directed transfers checked every cycle against a transaction-level expectation table
module tb_ahb2apb_bridge;
  logic        iPCLK;
  logic        iPRESET;
  logic        iHSEL;
  logic [31:0] iHADDR;
  logic [1:0]  iHTRANS;
  logic        iHWRITE;
  logic [31:0] iHWDATA;
  logic        iHREADY;
  logic        oHREADYOUT;
  logic        oHRESP;
  logic [31:0] oHRDATA;
  logic [31:0] oPADDR;
  logic        oPSEL0;
  logic        oPSEL1;
  logic        oPENABLE;
  logic        oPWRITE;
  logic [31:0] oPWDATA;
  logic [31:0] iPRDATA0;
  logic [31:0] iPRDATA1;
  logic        iPREADY0;
  logic        iPREADY1;
  ahb2apb_bridge dut (
    .iPCLK(iPCLK), .iPRESET(iPRESET), .iHSEL(iHSEL), .iHADDR(iHADDR), .iHTRANS(iHTRANS),
    .iHWRITE(iHWRITE), .iHWDATA(iHWDATA), .iHREADY(iHREADY), .oHREADYOUT(oHREADYOUT),
    .oHRESP(oHRESP), .oHRDATA(oHRDATA), .oPADDR(oPADDR), .oPSEL0(oPSEL0), .oPSEL1(oPSEL1),
    .oPENABLE(oPENABLE), .oPWRITE(oPWRITE), .oPWDATA(oPWDATA), .iPRDATA0(iPRDATA0),
    .iPRDATA1(iPRDATA1), .iPREADY0(iPREADY0), .iPREADY1(iPREADY1)
  );
  typedef struct packed {
    logic        hrdy;
    logic        resp;
    logic        sel0;
    logic        sel1;
    logic        en;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
  } outs_t;
  outs_t       expTab [int];
  outs_t       lastIdle;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int          lowCnt = 0;
  int          c;
  logic [31:0] mPaddr, mPwdata, mHrdata;
  logic        mPwrite;
  initial iPCLK = 1'b0;
  always #5 iPCLK = ~iPCLK;
  always @(posedge iPCLK) cyc <= cyc + 1;
  function automatic outs_t mk(input logic hrdy, resp, sel0, sel1, en, wr, input logic [31:0] addr, wd, rd);
    outs_t o;
    o.hrdy = hrdy; o.resp = resp; o.sel0 = sel0; o.sel1 = sel1; o.en = en;
    o.wr = wr; o.addr = addr; o.wd = wd; o.rd = rd;
    return o;
  endfunction
  function automatic logic idleLike(input outs_t o);
    return o.hrdy && !o.resp && !o.sel0 && !o.sel1 && !o.en;
  endfunction
  always @(negedge iPCLK) if (!iPRESET) begin : compare
    outs_t got, e;
    got = mk(oHREADYOUT, oHRESP, oPSEL0, oPSEL1, oPENABLE, oPWRITE, oPADDR, oPWDATA, oHRDATA);
    if (expTab.exists(cyc)) begin
      e = expTab[cyc];
      if (idleLike(e)) lastIdle = e;
    end else e = lastIdle;
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL cycle%0d outputs: got rdy=%b resp=%b sel=%b%b en=%b wr=%b addr=%h wd=%h rd=%h, want rdy=%b resp=%b sel=%b%b en=%b wr=%b addr=%h wd=%h rd=%h",
        cyc, got.hrdy, got.resp, got.sel0, got.sel1, got.en, got.wr, got.addr, got.wd, got.rd,
        e.hrdy, e.resp, e.sel0, e.sel1, e.en, e.wr, e.addr, e.wd, e.rd);
    end
    if (!oHREADYOUT) lowCnt++;
  end
  task automatic chk(input string name, input logic [31:0] got, want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask
  task automatic setReady(input logic s1, v);
    if (s1) iPREADY1 = v;
    else iPREADY0 = v;
  endtask
  task automatic idleBus();
    iHSEL = 1'b0; iHTRANS = 2'b00;
  endtask
  // presents one transfer in the current cycle and returns at the start of its completion cycle
  task automatic xfer(input logic wr, input logic [31:0] addr, wdata, input int waits, input logic noise);
    int b, s0, d;
    logic err, s1;
    outs_t e;
    b = cyc;
    err = (addr[31:28] != 4'h0) && (addr[31:28] != 4'h1);
    s1 = addr[31:28] == 4'h1;
    lowCnt = 0;
    mPaddr = addr; mPwrite = wr;
    e = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, wr, addr, mPwdata, mHrdata);
    iHSEL = 1'b1; iHTRANS = 2'b10; iHADDR = addr; iHWRITE = wr;
    if (err) begin
      s0 = 0;
      e.resp = 1'b1; expTab[b+1] = e;
      e.hrdy = 1'b1; expTab[b+2] = e;
      e.resp = 1'b0; expTab[b+3] = e;
      d = b + 3;
    end else begin
      if (wr) begin
        expTab[b+1] = e;
        mPwdata = wdata;
        e.wd = wdata;
      end
      s0 = b + 1 + int'(wr);
      e.sel0 = !s1; e.sel1 = s1;
      expTab[s0] = e;
      e.en = 1'b1;
      for (int k = 1; k <= waits + 1; k++) expTab[s0+k] = e;
      d = s0 + waits + 2;
      if (!wr) mHrdata = s1 ? iPRDATA1 : iPRDATA0;
      expTab[d] = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, wr, addr, mPwdata, mHrdata);
    end
    for (int k = b + 1; k <= d; k++) begin
      @(posedge iPCLK); #1;
      if (k == b + 1) iHWDATA = wdata;
      if (k == b + 2) iHWDATA = ~wdata;
      if (k < d && noise) begin
        iHSEL = 1'b1; iHTRANS = (k % 2) ? 2'b10 : 2'b11; iHADDR = 32'h1000_0FF0; iHWRITE = !wr;
      end else idleBus();
      if (!err && waits > 0) begin
        if (k == b + 1) setReady(s1, 1'b0);
        if (k == s0 + waits + 1) setReady(s1, 1'b1);
      end
    end
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    iPRESET = 1'b1; iHSEL = 1'b0; iHADDR = '0; iHTRANS = 2'b00; iHWRITE = 1'b0;
    iHWDATA = '0; iHREADY = 1'b1; iPRDATA0 = '0; iPRDATA1 = '0; iPREADY0 = 1'b1; iPREADY1 = 1'b1;
    mPaddr = '0; mPwdata = '0; mHrdata = '0; mPwrite = 1'b0;
    lastIdle = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    repeat (2) @(posedge iPCLK);
    #1;
    chk("reset_hreadyout", {31'd0, oHREADYOUT}, 32'd1);
    chk("reset_hresp", {31'd0, oHRESP}, 32'd0);
    chk("reset_hrdata", oHRDATA, 32'd0);
    chk("reset_psel_en", {29'd0, oPSEL0, oPSEL1, oPENABLE}, 32'd0);
    chk("reset_paddr", oPADDR, 32'd0);
    iPRESET = 1'b0;
    @(posedge iPCLK); #1;
    iHSEL = 1'b1; iHTRANS = 2'b01; iHADDR = 32'h0000_0020;
    @(posedge iPCLK); #1;
    iHTRANS = 2'b00;
    @(posedge iPCLK); #1;
    iHSEL = 1'b0; iHTRANS = 2'b10;
    @(posedge iPCLK); #1;
    idleBus();
    @(posedge iPCLK); #1;
    iPRDATA0 = 32'h0000_00A5; iPRDATA1 = 32'h5A5A_0001;
    xfer(1'b0, 32'h0000_0000, 32'h0, 0, 1'b0);
    chk("read_hrdata", oHRDATA, 32'h0000_00A5);
    chk("read_wait_states", lowCnt, 32'd2);
    xfer(1'b1, 32'h0000_0004, 32'h0000_00F0, 0, 1'b1);
    chk("write_wait_states", lowCnt, 32'd3);
    chk("write_paddr", oPADDR, 32'h0000_0004);
    chk("write_pwdata", oPWDATA, 32'h0000_00F0);
    chk("write_pwrite", {31'd0, oPWRITE}, 32'd1);
    chk("write_keeps_hrdata", oHRDATA, 32'h0000_00A5);
    iPRDATA1 = 32'h1234_5678;
    xfer(1'b0, 32'h1000_0008, 32'h0, 3, 1'b0);
    chk("wait_wait_states", lowCnt, 32'd5);
    chk("wait_hrdata", oHRDATA, 32'h1234_5678);
    xfer(1'b0, 32'h2000_0000, 32'h0, 0, 1'b0);
    chk("decode_err_wait_states", lowCnt, 32'd1);
    iPRDATA0 = 32'h0000_C0DE;
    xfer(1'b1, 32'h0000_0008, 32'hDEAD_BEEF, 0, 1'b0);
    chk("b2b_write_wait_states", lowCnt, 32'd3);
    xfer(1'b0, 32'h0000_000C, 32'h0, 0, 1'b0);
    chk("b2b_read_wait_states", lowCnt, 32'd2);
    chk("b2b_read_hrdata", oHRDATA, 32'h0000_C0DE);
    xfer(1'b1, 32'h1000_0010, 32'h0BAD_F00D, 1, 1'b1);
    chk("write_s1_wait_states", lowCnt, 32'd4);
    @(posedge iPCLK); #1;
    c = cyc;
    iPRDATA0 = 32'h0000_0077; iPREADY0 = 1'b0;
    iHSEL = 1'b1; iHTRANS = 2'b10; iHADDR = 32'h0000_0010; iHWRITE = 1'b0;
    expTab[c+1] = mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h10, mPwdata, mHrdata);
    expTab[c+2] = mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h10, mPwdata, mHrdata);
    @(posedge iPCLK); #1;
    idleBus();
    @(posedge iPCLK); #1;
    @(posedge iPCLK); #2;
    iPRESET = 1'b1;
    #1;
    chk("abort_psel_en", {29'd0, oPSEL0, oPSEL1, oPENABLE}, 32'd0);
    chk("abort_hreadyout", {31'd0, oHREADYOUT}, 32'd1);
    chk("abort_hrdata", oHRDATA, 32'd0);
    chk("abort_paddr", oPADDR, 32'd0);
    expTab.delete();
    mPaddr = '0; mPwdata = '0; mHrdata = '0; mPwrite = 1'b0;
    lastIdle = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    iPREADY0 = 1'b1;
    @(posedge iPCLK); #1;
    iPRESET = 1'b0;
    @(posedge iPCLK); #1;
    iPRDATA0 = 32'h0000_0BAD;
    xfer(1'b0, 32'h0000_0010, 32'h0, 0, 1'b0);
    chk("recover_hrdata", oHRDATA, 32'h0000_0BAD);
    repeat (3) @(posedge iPCLK);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
